pipe_skid_reg: RTL

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It replaces fixed inter-stage latches (ID/EX, EX/MEM, MEM/WB) with one reusable block. The block adds back-pressure, a whole-stage flush, and a per-entry control squash (bubble injection) while keeping the payload. Each stage carries a wide data word and a narrow control word; the control word is forced to a bubble value whenever no valid entry is presented.

---
 rtl/pipe_skid_reg.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Reusable pipeline stage register with a valid/ready handshake and a
// one-entry skid buffer. It replaces a fixed inter-stage latch (ID/EX, EX/MEM,
// MEM/WB) and adds back-pressure, a whole-stage flush, and a per-entry control
// squash that turns the presented entry into a bubble while it keeps its
// payload.
//
// Storage is a main register, which drives the outputs, and a skid register
// that absorbs the single entry still in flight when downstream stalls.
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output. In particular, in_ready does not follow
// out_ready within the same cycle.
//
// Parameters
//   DATA_W       payload width
//   CTRL_W       control-word width
//   CTRL_BUBBLE  control value shown for an empty or squashed slot
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous; discards every held entry
//   squash     in   synchronous; bubbles the presented entry's control word
//   in_valid   in   upstream entry valid
//   in_ready   out  block can accept (registered)
//   in_data    in   upstream payload
//   in_ctrl    in   upstream control word
//   out_valid  out  entry presented downstream (registered)
//   out_ready  in   downstream accepts
//   out_data   out  presented payload (registered)
//   out_ctrl   out  presented control word (registered)
//   occupancy  out  number of held entries, 0..2 (registered)
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int                DATA_W      = 128,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              squash,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Occupancy-encoded states. The encoding equals the entry count, so the
    // occupancy flop loads the same value as the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,  // nothing held
        ST_ONE   = 2'd1,  // main valid
        ST_FULL  = 2'd2   // main and skid valid
    } state_e;

    // What the main register loads on the coming edge.
    typedef enum logic [1:0] {
        MAIN_HOLD   = 2'd0,  // keep data and control
        MAIN_IN     = 2'd1,  // take the upstream entry
        MAIN_SKID   = 2'd2,  // promote the skid entry
        MAIN_BUBBLE = 2'd3   // control to CTRL_BUBBLE, data kept
    } main_op_e;

    state_e            state_q;
    state_e            state_d;
    main_op_e          main_op;
    logic              skid_load;

    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [1:0]        occupancy_q;

    logic              accept;
    logic              pop;

    // The handshake uses only registered qualifiers, so upstream and
    // downstream timing stay decoupled.
    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // -------------------------------------------------------------------------
    // Next-state and datapath steering
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default on entry, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        main_op   = MAIN_HOLD;
        skid_load = 1'b0;

        if (flush) begin
            // A flush overrides everything. A same-cycle accept is dropped,
            // and a same-cycle pop has already been seen downstream.
            state_d = ST_EMPTY;
            main_op = MAIN_BUBBLE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    // out_valid is 0 here, so neither pop nor squash applies.
                    if (accept) begin
                        main_op = MAIN_IN;
                        state_d = ST_ONE;
                    end
                end

                ST_ONE: begin
                    if (accept && pop) begin
                        // Pass-through at full rate. The new entry replaces
                        // the leaving one, and a squash on the leaving entry
                        // is moot.
                        main_op = MAIN_IN;
                    end else if (accept) begin
                        // Downstream stalled with one entry in flight. Park
                        // the new entry in the skid register. A squash here
                        // still applies to the presented main entry.
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                        if (squash) begin
                            main_op = MAIN_BUBBLE;
                        end
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                        main_op = MAIN_BUBBLE;
                    end else if (squash) begin
                        main_op = MAIN_BUBBLE;
                    end
                end

                ST_FULL: begin
                    // in_ready is 0 in FULL, so accept cannot occur here.
                    if (pop) begin
                        main_op = MAIN_SKID;
                        state_d = ST_ONE;
                    end else if (squash) begin
                        main_op = MAIN_BUBBLE;
                    end
                end

                default: begin
                    // Unused encoding: recover to a clean empty stage.
                    state_d = ST_EMPTY;
                    main_op = MAIN_BUBBLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and registered handshake/status outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_FULL);
            occupancy_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Main register (drives the outputs)
    // -------------------------------------------------------------------------
    // NOTE: the wide payload registers are reset on purpose. A defined zero on
    // out_data and in the skid register after reset is part of the block's
    // contract, so downstream never sees X payloads on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_ctrl_q <= CTRL_BUBBLE;
        end else begin
            unique case (main_op)
                MAIN_IN: begin
                    main_data_q <= in_data;
                    main_ctrl_q <= in_ctrl;
                end
                MAIN_SKID: begin
                    main_data_q <= skid_data_q;
                    main_ctrl_q <= skid_ctrl_q;
                end
                MAIN_BUBBLE: begin
                    // The payload is kept, and only the control word is
                    // neutralised.
                    main_ctrl_q <= CTRL_BUBBLE;
                end
                default: begin
                    // MAIN_HOLD: keep the current contents.
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Skid register
    // -------------------------------------------------------------------------
    // A flush does not clear it. Leaving the FULL state makes its contents
    // dead, and they are overwritten before they are used again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (skid_load) begin
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = occupancy_q;

    // -------------------------------------------------------------------------
    // Structural invariants
    // -------------------------------------------------------------------------
    a_occ_range : assert property (@(posedge clk) disable iff (!rst_n)
        occupancy_q != 2'd3);

    a_valid_matches_state : assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_q == (state_q != ST_EMPTY));

    a_ready_matches_state : assert property (@(posedge clk) disable iff (!rst_n)
        in_ready_q == (state_q != ST_FULL));

    a_empty_is_bubble : assert property (@(posedge clk) disable iff (!rst_n)
        !out_valid_q |-> (main_ctrl_q == CTRL_BUBBLE));

endmodule
